// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate generator producing sext imm, format code, pc+imm target and illegal flag.
// Latency: STAGES cycles (1 or 2) from an accepted input beat to out_valid.
// Backpressure: per-stage valid/ready, in_ready = !valid_last | out_ready chained back; stalled outputs hold.
module imm_gen_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] target,
   output logic [2:0]      fmt,
   output logic            illegal
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;

   // Elaboration-time guard on the only supported configurations.
   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("imm_gen_pipe: XLEN must be 32 or 64");
      end
      if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
         $error("imm_gen_pipe: STAGES must be 1 or 2");
      end
   endgenerate

   logic [6:0]      opcode;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;
   logic [31:0]     dec_imm32;
   logic [XLEN-1:0] dec_imm;

   assign opcode = inst[6:0];

   // Classify the opcode into a format; the *-32 opcodes only exist on RV64.
   always_comb begin
      dec_fmt     = FMT_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: dec_fmt = FMT_I;
         OP_IMM32: begin
            if (XLEN == 64) dec_fmt = FMT_I;
            else            dec_illegal = 1'b1;
         end
         OP_STORE:         dec_fmt = FMT_S;
         OP_BRANCH:        dec_fmt = FMT_B;
         OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
         OP_JAL:           dec_fmt = FMT_J;
         OP_OP:            dec_fmt = FMT_NONE;
         OP_OP32: begin
            if (XLEN != 64) dec_illegal = 1'b1;
         end
         default:          dec_illegal = 1'b1;
      endcase
   end

   // Gather the scattered immediate bits into a 32-bit sign-extended value.
   always_comb begin
      dec_imm32 = 32'd0;
      case (dec_fmt)
         FMT_I: dec_imm32 = {{20{inst[31]}}, inst[31:20]};
         FMT_S: dec_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B: dec_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U: dec_imm32 = {inst[31:12], 12'd0};
         FMT_J: dec_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: dec_imm32 = 32'd0;
      endcase
   end

   // Widen to XLEN; only RV64 sees the upper sign copies (e.g. lui with bit 31 set).
   generate
      if (XLEN == 64) begin : g_ext64
         assign dec_imm = {{32{dec_imm32[31]}}, dec_imm32};
      end else begin : g_ext32
         assign dec_imm = dec_imm32;
      end
   endgenerate

   generate
      if (STAGES == 1) begin : g_one
         logic            v_q, v_d;
         logic [XLEN-1:0] imm_q, imm_d;
         logic [XLEN-1:0] tgt_q, tgt_d;
         logic [2:0]      fmt_q, fmt_d;
         logic            ill_q, ill_d;
         logic            acc;

         // Single output stage: accept when empty or draining, flush wins over accept.
         always_comb begin
            in_ready = ~v_q | out_ready;
            acc      = in_valid & in_ready & ~flush;
            v_d      = v_q;
            imm_d    = imm_q;
            tgt_d    = tgt_q;
            fmt_d    = fmt_q;
            ill_d    = ill_q;
            if (flush)         v_d = 1'b0;
            else if (in_ready) v_d = in_valid;
            if (acc) begin
               imm_d = dec_imm;
               tgt_d = pc + dec_imm;
               fmt_d = dec_fmt;
               ill_d = dec_illegal;
            end
         end

         // Stage register with synchronous reset clearing valid and data.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_q   <= 1'b0;
               imm_q <= '0;
               tgt_q <= '0;
               fmt_q <= FMT_NONE;
               ill_q <= 1'b0;
            end else begin
               v_q   <= v_d;
               imm_q <= imm_d;
               tgt_q <= tgt_d;
               fmt_q <= fmt_d;
               ill_q <= ill_d;
            end
         end

         assign out_valid = v_q;
         assign imm       = imm_q;
         assign target    = tgt_q;
         assign fmt       = fmt_q;
         assign illegal   = ill_q;
      end else begin : g_two
         // Stage 1 holds decode results plus pc; the wide add is deferred to stage 2.
         logic            v1_q, v1_d;
         logic [XLEN-1:0] imm1_q, imm1_d;
         logic [XLEN-1:0] pc1_q, pc1_d;
         logic [2:0]      fmt1_q, fmt1_d;
         logic            ill1_q, ill1_d;
         logic            v2_q, v2_d;
         logic [XLEN-1:0] imm2_q, imm2_d;
         logic [XLEN-1:0] tgt2_q, tgt2_d;
         logic [2:0]      fmt2_q, fmt2_d;
         logic            ill2_q, ill2_d;
         logic            rdy2, acc1, mv2;

         // Ready chain runs back from the consumer; both stages can move on the same edge.
         always_comb begin
            rdy2     = ~v2_q | out_ready;
            in_ready = ~v1_q | rdy2;
            acc1     = in_valid & in_ready & ~flush;
            mv2      = v1_q & rdy2 & ~flush;

            v1_d   = v1_q;
            imm1_d = imm1_q;
            pc1_d  = pc1_q;
            fmt1_d = fmt1_q;
            ill1_d = ill1_q;
            v2_d   = v2_q;
            imm2_d = imm2_q;
            tgt2_d = tgt2_q;
            fmt2_d = fmt2_q;
            ill2_d = ill2_q;

            if (flush)         v1_d = 1'b0;
            else if (in_ready) v1_d = in_valid;
            if (flush)         v2_d = 1'b0;
            else if (rdy2)     v2_d = v1_q;

            if (acc1) begin
               imm1_d = dec_imm;
               pc1_d  = pc;
               fmt1_d = dec_fmt;
               ill1_d = dec_illegal;
            end
            if (mv2) begin
               imm2_d = imm1_q;
               tgt2_d = pc1_q + imm1_q;
               fmt2_d = fmt1_q;
               ill2_d = ill1_q;
            end
         end

         // Both stage registers, synchronous reset clears valids and data.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v1_q   <= 1'b0;
               imm1_q <= '0;
               pc1_q  <= '0;
               fmt1_q <= FMT_NONE;
               ill1_q <= 1'b0;
               v2_q   <= 1'b0;
               imm2_q <= '0;
               tgt2_q <= '0;
               fmt2_q <= FMT_NONE;
               ill2_q <= 1'b0;
            end else begin
               v1_q   <= v1_d;
               imm1_q <= imm1_d;
               pc1_q  <= pc1_d;
               fmt1_q <= fmt1_d;
               ill1_q <= ill1_d;
               v2_q   <= v2_d;
               imm2_q <= imm2_d;
               tgt2_q <= tgt2_d;
               fmt2_q <= fmt2_d;
               ill2_q <= ill2_d;
            end
         end

         assign out_valid = v2_q;
         assign imm       = imm2_q;
         assign target    = tgt2_q;
         assign fmt       = fmt2_q;
         assign illegal   = ill2_q;
      end
   endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (32/1, 32/2, 64/2) share one input stream.
// Each has its own behavioural slot model; a negedge process compares every cycle.
// Directed literal checks pin the test-plan values before a long randomized run.
module tb_imm_gen_pipe;

   typedef struct packed {
      logic [63:0] imm;
      logic [63:0] tgt;
      logic [2:0]  fmt;
      logic        ill;
   } ent_t;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] inst;
   logic [63:0] pc;

   logic        rdy0, ov0, ill0, rdy1, ov1, ill1, rdy2, ov2, ill2;
   logic [31:0] imm0, tgt0, imm1, tgt1;
   logic [63:0] imm2, tgt2;
   logic [2:0]  fmt0, fmt1, fmt2;

   logic        a_rdy [NI];
   logic        a_ov  [NI];
   logic        a_ill [NI];
   logic [63:0] a_imm [NI];
   logic [63:0] a_tgt [NI];
   logic [2:0]  a_fmt [NI];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .STAGES(1)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
      .inst(inst), .pc(pc[31:0]), .out_valid(ov0), .out_ready(out_ready),
      .imm(imm0), .target(tgt0), .fmt(fmt0), .illegal(ill0));

   imm_gen_pipe #(.XLEN(32), .STAGES(2)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
      .inst(inst), .pc(pc[31:0]), .out_valid(ov1), .out_ready(out_ready),
      .imm(imm1), .target(tgt1), .fmt(fmt1), .illegal(ill1));

   imm_gen_pipe #(.XLEN(64), .STAGES(2)) u2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
      .inst(inst), .pc(pc), .out_valid(ov2), .out_ready(out_ready),
      .imm(imm2), .target(tgt2), .fmt(fmt2), .illegal(ill2));

   always_comb begin
      a_rdy[0] = rdy0; a_ov[0] = ov0; a_ill[0] = ill0; a_fmt[0] = fmt0;
      a_imm[0] = {32'd0, imm0}; a_tgt[0] = {32'd0, tgt0};
      a_rdy[1] = rdy1; a_ov[1] = ov1; a_ill[1] = ill1; a_fmt[1] = fmt1;
      a_imm[1] = {32'd0, imm1}; a_tgt[1] = {32'd0, tgt1};
      a_rdy[2] = rdy2; a_ov[2] = ov2; a_ill[2] = ill2; a_fmt[2] = fmt2;
      a_imm[2] = imm2; a_tgt[2] = tgt2;
   end

   function automatic int nst(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic int xl(input int k);
      return (k == 2) ? 64 : 32;
   endfunction

   task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d got=%h expected=%h @%0t", nm, k, got, exp, $time);
      end
   endtask

   // n-bit field of w starting at bit lo, as a non-negative number
   function automatic longint fld(input logic [31:0] w, input int lo, input int n);
      logic [31:0] t;
      t = (w >> lo) & ((32'd1 << n) - 32'd1);
      return longint'(t);
   endfunction

   // Reference decode written as arithmetic on fields: value = sign*2^k + sum(field*2^pos)
   function automatic ent_t ref_dec(input logic [31:0] w, input logic [63:0] p, input int x);
      ent_t        e;
      longint      v, sgn;
      logic [6:0]  op;
      logic [63:0] mask;
      op   = w[6:0];
      sgn  = w[31] ? -64'sd1 : 64'sd0;
      v    = 0;
      e.fmt = 3'd0;
      e.ill = 1'b0;
      mask = (x == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      if (op inside {7'h03, 7'h13, 7'h67, 7'h73} || (op == 7'h1B && x == 64)) begin
         e.fmt = 3'd1; v = (sgn << 12) | fld(w, 20, 12);
      end else if (op == 7'h23) begin
         e.fmt = 3'd2; v = (sgn << 12) | (fld(w, 25, 7) << 5) | fld(w, 7, 5);
      end else if (op == 7'h63) begin
         e.fmt = 3'd3;
         v = (sgn << 12) | (fld(w, 7, 1) << 11) | (fld(w, 25, 6) << 5) | (fld(w, 8, 4) << 1);
      end else if (op inside {7'h37, 7'h17}) begin
         e.fmt = 3'd4; v = (sgn << 32) | (fld(w, 12, 20) << 12);
      end else if (op == 7'h6F) begin
         e.fmt = 3'd5;
         v = (sgn << 20) | (fld(w, 12, 8) << 12) | (fld(w, 20, 1) << 11) | (fld(w, 21, 10) << 1);
      end else if (op == 7'h33 || (op == 7'h3B && x == 64)) begin
         e.fmt = 3'd0;
      end else begin
         e.ill = 1'b1;
      end
      e.imm = 64'(v) & mask;
      e.tgt = ((p & mask) + e.imm) & mask;
      return e;
   endfunction

   // ---------------- behavioural model ----------------
   bit   m_v     [NI][2];
   ent_t m_e     [NI][2];
   bit   zero_ok [NI];
   bit   started = 1'b0;

   task automatic model_step(input int k);
      int n;
      bit rl, r0;
      n = nst(k);
      if (!rst_n) begin
         for (int s = 0; s < 2; s++) begin
            m_v[k][s] = 1'b0;
            m_e[k][s] = '0;
         end
         zero_ok[k] = 1'b1;
      end else if (flush) begin
         for (int s = 0; s < 2; s++) m_v[k][s] = 1'b0;
      end else begin
         rl = !m_v[k][n-1] || out_ready;
         r0 = (n == 1) ? rl : (!m_v[k][0] || rl);
         if (n == 2 && rl) begin
            if (m_v[k][0]) begin
               m_e[k][1]  = m_e[k][0];
               zero_ok[k] = 1'b0;
            end
            m_v[k][1] = m_v[k][0];
         end
         if (r0) begin
            m_v[k][0] = in_valid;
            if (in_valid) begin
               m_e[k][0] = ref_dec(inst, pc, xl(k));
               if (n == 1) zero_ok[k] = 1'b0;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) started = 1'b1;
      for (int k = 0; k < NI; k++) model_step(k);
   end

   // Compare every DUT against its model on each falling edge.
   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < NI; k++) begin
            int  last;
            bit  rl, r0;
            last = nst(k) - 1;
            rl   = !m_v[k][last] || out_ready;
            r0   = (last == 0) ? rl : (!m_v[k][0] || rl);
            chk("in_ready", k, 64'(a_rdy[k]), 64'(r0));
            chk("out_valid", k, 64'(a_ov[k]), 64'(m_v[k][last]));
            if (m_v[k][last] || zero_ok[k]) begin
               chk("imm", k, a_imm[k], m_e[k][last].imm);
               chk("target", k, a_tgt[k], m_e[k][last].tgt);
               chk("fmt", k, 64'(a_fmt[k]), 64'(m_e[k][last].fmt));
               chk("illegal", k, 64'(a_ill[k]), 64'(m_e[k][last].ill));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string nm);
      for (int k = 0; k < NI; k++) begin
         chk({nm, "_ov"}, k, 64'(a_ov[k]), 64'd0);
         chk({nm, "_rdy"}, k, 64'(a_rdy[k]), 64'd1);
         chk({nm, "_imm"}, k, a_imm[k], 64'd0);
         chk({nm, "_tgt"}, k, a_tgt[k], 64'd0);
         chk({nm, "_fmt"}, k, 64'(a_fmt[k]), 64'd0);
         chk({nm, "_ill"}, k, 64'(a_ill[k]), 64'd0);
      end
   endtask

   logic [6:0] ops [13] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};

   initial begin
      logic [31:0] r;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inst = '0; pc = '0;
      repeat (3) step();
      rst_n = 1'b1;
      check_cleared("reset");

      // addi x1,x0,-1 at pc 0
      inst = 32'hFFF00093; pc = 64'h0; in_valid = 1'b1;
      step(); in_valid = 1'b0;
      chk("addi_ov", 0, 64'(a_ov[0]), 64'd1);
      chk("addi_imm", 0, a_imm[0], 64'hFFFF_FFFF);
      chk("addi_tgt", 0, a_tgt[0], 64'hFFFF_FFFF);
      chk("addi_fmt", 0, 64'(a_fmt[0]), 64'd1);
      chk("addi_ill", 0, 64'(a_ill[0]), 64'd0);
      chk("addi_lat2", 1, 64'(a_ov[1]), 64'd0);
      step();
      chk("addi_ov2", 1, 64'(a_ov[1]), 64'd1);
      chk("addi_imm64", 2, a_imm[2], 64'hFFFF_FFFF_FFFF_FFFF);
      step();

      // lui then jal back to back
      inst = 32'h12345037; pc = 64'hFC; in_valid = 1'b1;
      step();
      chk("lui_imm", 0, a_imm[0], 64'h1234_5000);
      chk("lui_fmt", 0, 64'(a_fmt[0]), 64'd4);
      inst = 32'h0080006F; pc = 64'h100;
      step(); in_valid = 1'b0;
      chk("jal_imm", 0, a_imm[0], 64'h8);
      chk("jal_fmt", 0, 64'(a_fmt[0]), 64'd5);
      chk("jal_tgt", 0, a_tgt[0], 64'h108);
      chk("b2b_lui", 1, a_imm[1], 64'h1234_5000);
      step();
      chk("b2b_jal", 1, a_tgt[1], 64'h108);
      step();

      // RV64 lui sign extension and op-imm-32
      inst = 32'h800000B7; pc = 64'h0; in_valid = 1'b1;
      step(); in_valid = 1'b0;
      step();
      chk("lui64_imm", 2, a_imm[2], 64'hFFFF_FFFF_8000_0000);
      chk("lui32_imm", 1, a_imm[1], 64'h8000_0000);
      inst = 32'h0000001B; pc = 64'h40; in_valid = 1'b1;
      step(); in_valid = 1'b0;
      chk("w32_ill", 0, 64'(a_ill[0]), 64'd1);
      chk("w32_imm", 0, a_imm[0], 64'd0);
      chk("w32_tgt", 0, a_tgt[0], 64'h40);
      step();
      chk("w64_fmt", 2, 64'(a_fmt[2]), 64'd1);
      chk("w64_ill", 2, 64'(a_ill[2]), 64'd0);

      // add then an unknown opcode
      inst = 32'h00000033; pc = 64'h80; in_valid = 1'b1;
      step();
      chk("add_fmt", 0, 64'(a_fmt[0]), 64'd0);
      chk("add_ill", 0, 64'(a_ill[0]), 64'd0);
      chk("add_tgt", 0, a_tgt[0], 64'h80);
      inst = 32'h0000007F;
      step(); in_valid = 1'b0;
      chk("op7f_ill", 0, 64'(a_ill[0]), 64'd1);
      step(); step();

      // beq -4 under backpressure on the 2-stage pipes
      out_ready = 1'b0;
      inst = 32'hFE000EE3; pc = 64'h200; in_valid = 1'b1;
      step();
      chk("beq_lat", 1, 64'(a_ov[1]), 64'd0);
      inst = 32'h00100093; pc = 64'h204;
      step(); in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("beq_ov", 1, 64'(a_ov[1]), 64'd1);
         chk("beq_imm", 1, a_imm[1], 64'hFFFF_FFFC);
         chk("beq_tgt", 1, a_tgt[1], 64'h1FC);
         chk("beq_fmt", 1, 64'(a_fmt[1]), 64'd3);
         chk("beq_full_rdy", 1, 64'(a_rdy[1]), 64'd0);
         chk("beq_tgt64", 2, a_tgt[2], 64'h1FC);
         if (c < 2) step();
      end
      out_ready = 1'b1;
      step();
      chk("nobubble_ov", 1, 64'(a_ov[1]), 64'd1);
      chk("nobubble_tgt", 1, a_tgt[1], 64'h205);
      step(); step();

      // flush with both stages full plus a new beat
      out_ready = 1'b0; in_valid = 1'b1;
      inst = 32'h00200093; pc = 64'h300;
      step();
      inst = 32'h00300093; pc = 64'h304;
      step();
      flush = 1'b1; inst = 32'h00400093; pc = 64'h308;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         for (int k = 0; k < NI; k++) chk("flush_ov", k, 64'(a_ov[k]), 64'd0);
         step();
      end

      // reset in the middle of a stream
      inst = 32'h12345037; pc = 64'h500; in_valid = 1'b1;
      step(); step();
      rst_n = 1'b0;
      step();
      check_cleared("midrst");
      rst_n = 1'b1; in_valid = 1'b0;
      step();

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         r         = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = (c % 200 < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         rst_n     = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 9) != 0) inst = {r[31:7], ops[$urandom_range(0, 12)]};
         else                           inst = r;
         pc = {$urandom, $urandom};
         step();
      end

      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
